// File: rtl/single_port_ram_pkg.sv
// Shared types and constants for the single-port RAM with clear sequencer.
// Imported by the clear sequencer and the RAM top level.
package single_port_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    INIT  = 2'd2
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every word address after reset or on clr,
// and gates access requests through ready.
module ram_clear_seq
  import single_port_ram_pkg::*;
#(
  parameter int RAM_DEPTH    = 256,
  parameter int LB_RAM_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  output logic                    ready,
  output logic                    busy,
  output logic                    init_we,
  output logic [LB_RAM_DEPTH-1:0] init_addr
);

  localparam logic [LB_RAM_DEPTH-1:0] LAST =
    LB_RAM_DEPTH'(RAM_DEPTH - 1);

  state_t                  state_q, state_d;
  logic [LB_RAM_DEPTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    busy    = 1'b1;
    init_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (clr) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = INIT;
      end
      INIT: begin
        init_we = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign init_addr = cnt_q;

endmodule

// File: rtl/single_port_ram_init.sv
// Single-port synchronous RAM with byte enables, 2-stage access
// pipeline, selectable read-during-write and a hardware clear.
module single_port_ram_init
  import single_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 256,
  parameter int BYTE_WIDTH = 8,
  parameter int RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int NUM_BYTES    = DATA_WIDTH / BYTE_WIDTH,
  localparam int LB_RAM_DEPTH = $clog2(RAM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  output logic                    busy,
  input  logic                    req,
  output logic                    ready,
  input  logic                    we,
  input  logic [NUM_BYTES-1:0]    be,
  input  logic [LB_RAM_DEPTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid
);

  localparam logic [LB_RAM_DEPTH:0] DEPTH_W =
    (LB_RAM_DEPTH + 1)'(RAM_DEPTH);

  logic                    init_we;
  logic [LB_RAM_DEPTH-1:0] init_addr;

  ram_clear_seq #(
    .RAM_DEPTH    (RAM_DEPTH),
    .LB_RAM_DEPTH (LB_RAM_DEPTH)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .ready     (ready),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  logic                    acc;
  logic                    s1_valid;
  logic                    s1_we;
  logic [NUM_BYTES-1:0]    s1_be;
  logic [LB_RAM_DEPTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0]   s1_din;

  assign acc = req && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_we    <= 1'b0;
      s1_be    <= '0;
      s1_addr  <= '0;
      s1_din   <= '0;
    end else begin
      s1_valid <= acc;
      if (acc) begin
        s1_we   <= we;
        s1_be   <= be;
        s1_addr <= addr;
        s1_din  <= din;
      end
    end
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic                  in_range;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] wr_dout;

  assign in_range = {1'b0, s1_addr} < DEPTH_W;
  assign rd_word  = in_range ? mem[s1_addr] : '0;

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (s1_be[i])
        merged[i*BYTE_WIDTH +: BYTE_WIDTH] =
          s1_din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Out-of-range writes leave nothing behind, so no merged word either.
  always_comb begin
    wr_dout = dout;
    unique case (RDW_MODE)
      RDW_READ_FIRST:  wr_dout = rd_word;
      RDW_WRITE_FIRST: wr_dout = in_range ? merged : rd_word;
      default:         wr_dout = dout;
    endcase
  end

  // The sequencer only runs when stage 1 is empty; it still wins.
  always_ff @(posedge clk) begin
    if (init_we)
      mem[init_addr] <= INIT_VALUE;
    else if (s1_valid && s1_we && in_range)
      mem[s1_addr] <= merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= s1_valid && !s1_we;
      if (s1_valid)
        dout <= s1_we ? wr_dout : rd_word;
    end
  end

endmodule

// File: doc/single_port_ram_init.md
Name: single_port_ram_init

Overview:
- Next-generation single-port synchronous RAM for the interleaved FIFO datapath.
- Keeps the 2-stage registered access pipeline (input register, then registered array output).
- Adds:
  - per-byte write enables,
  - selectable read-during-write behaviour,
  - request/ready/valid handshake,
  - hardware clear sequencer that writes INIT_VALUE to every word after reset or on request.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH.
- RAM_DEPTH, 256, number of words; need not be a power of 2.
- BYTE_WIDTH, 8, width of one byte lane.
- RDW_MODE, 0, data on dout for a write access: 0 = old word, 1 = merged new word, 2 = dout unchanged.
- INIT_VALUE, 0, word value written by the clear sequencer.
- Derived localparams: NUM_BYTES = DATA_WIDTH/BYTE_WIDTH; LB_RAM_DEPTH = $clog2(RAM_DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  request a full re-clear; sampled only in IDLE.
- busy  out  1  high while the clear sequence is pending or running.
- req  in  1  access request; accepted when req && ready.
- ready  out  1  high only in IDLE.
- we  in  1  1 = write, 0 = read; qualified by req.
- be  in  NUM_BYTES  byte-lane write enables; lane i = din[i*BYTE_WIDTH +: BYTE_WIDTH].
- addr  in  LB_RAM_DEPTH  word address.
- din  in  DATA_WIDTH  write data.
- dout  out  DATA_WIDTH  registered read data.
- dout_valid  out  1  one-cycle pulse marking read data on dout.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = INIT, clear counter = 0;
  - stage-1 valid = 0, dout = 0, dout_valid = 0, ready = 0, busy = 1.
  - Array contents are not reset. They are rewritten by the clear sequence after rst_n rises.
- Pipeline, for a request accepted in cycle T:
  - Edge ending T: we, be, addr and din are registered into stage 1.
  - Edge ending T+1: array write for a write access; registered array read for a read access.
  - Cycle T+2: dout is valid; dout_valid = 1 for read accesses only.
  - One access per cycle; back-to-back accesses are allowed with no bubbles.
- Ordering:
  - A read accepted in T+1 at the same address as a write accepted in T returns the new data.
  - Read latency is fixed at 2 cycles.
- Byte lanes:
  - On a write, only lanes with be[i] = 1 are updated.
  - we = 1 with be = 0 is accepted and changes nothing.
- RDW_MODE, applied on write accesses (dout_valid stays 0 in all modes):
  - 0: dout = pre-write word.
  - 1: dout = merged post-write word.
  - 2: dout holds its previous value.
- Out-of-range addr (addr >= RAM_DEPTH): write is dropped; read returns 0 with dout_valid = 1.
- State machine:
  - INIT: ready = 0, busy = 1.
    - Each cycle, write INIT_VALUE (all lanes) at the counter address, then increment the counter.
    - After writing address RAM_DEPTH-1, go to IDLE; the counter returns to 0.
    - The sequence takes exactly RAM_DEPTH cycles.
  - IDLE: ready = 1, busy = 0.
    - clr = 1 moves to DRAIN.
    - A req in the same cycle as clr is still accepted and completes normally.
  - DRAIN: ready = 0, busy = 1.
    - Lasts one cycle so the stage-1 access can finish, including its dout_valid pulse in the following cycle.
    - Then go to INIT.
- Handshake rules:
  - req while ready = 0 is ignored: no access and no response.
  - clr outside IDLE is ignored.
- Reset mid-operation: any in-flight access is discarded (no dout_valid), and the sequence restarts from address 0.

Decomposition:
- Package single_port_ram_pkg holds:
  - the state enum {IDLE, DRAIN, INIT};
  - RDW constants RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1, RDW_NO_CHANGE = 2.
- One sub-module, ram_clear_seq, contains the FSM and address counter. Its ports: clk, rst_n, clr, ready, busy, init_we, init_addr.
- The top level muxes the array port between the stage-1 access and ram_clear_seq.

Test Plan (defaults: DATA_WIDTH 32, BYTE_WIDTH 8, RAM_DEPTH 256, INIT_VALUE 0):
- Clear after reset: release rst_n.
  - busy = 1 and ready = 0 for exactly 256 cycles, then ready = 1.
  - A read of addr 0xFF returns 0x00000000 with dout_valid exactly 2 cycles after acceptance.
- Byte enables:
  - Write 0xDEADBEEF to addr 5 with be = 4'hF.
  - Write 0x11223344 to addr 5 with be = 4'b0101.
  - Read addr 5 → 0xDE22BE44.
- Back-to-back:
  - Write 0xCAFEF00D to addr 9 in cycle T, read addr 9 in T+1 → dout = 0xCAFEF00D in T+3.
  - dout_valid is low in T+2 and high in T+3.
- RDW_MODE 0/1/2: addr 3 holds 0xAAAAAAAA; write 0x55555555 with be = 4'hF. On the write's dout cycle:
  - mode 0: dout = 0xAAAAAAAA;
  - mode 1: dout = 0x55555555;
  - mode 2: dout holds its prior value;
  - dout_valid = 0 in every mode.
- clr with concurrent read: write 0x12345678 to addr 7, then assert req (read addr 7) and clr in the same cycle.
  - The read returns 0x12345678 with dout_valid.
  - Then busy = 1 for 257 cycles (DRAIN plus 256 INIT).
  - A re-read of addr 7 returns 0.
- Reset mid-INIT and mid-read:
  - Pull rst_n low during INIT cycle 100 and during an accepted read.
  - dout = 0, no dout_valid pulse, and a full 256-cycle INIT restarts after release.
